// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between I-cache refills and D-cache
// refills/write-backs; one line-sized transaction in flight, with a response watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_resp_valid,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_resp_valid,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // WAIT is entered with the counter at 0, so the watchdog fires when the
    // counter would step onto TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic                owner_d_q, owner_d_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                ic_resp_q, ic_resp_d;
    logic                dc_resp_q, dc_resp_d;
    logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                pick_d;
    logic                done;
    logic [LINE_W-1:0]   done_data;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        owner_d_d   = owner_d_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ic_resp_d   = 1'b0;
        dc_resp_d   = 1'b0;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        err_d       = 1'b0;
        pick_d      = 1'b0;
        done        = 1'b0;
        done_data   = '0;
        case (state_q)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    // On a tie the side that did not win last time gets the port.
                    pick_d      = dc_req && (!ic_req || !last_d_q);
                    owner_d_d   = pick_d;
                    last_d_d    = pick_d;
                    mem_we_d    = pick_d && dc_we;
                    mem_addr_d  = pick_d ? dc_addr : ic_addr;
                    mem_wdata_d = pick_d ? dc_wdata : '0;
                    mem_req_d   = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    done      = 1'b1;
                    done_data = mem_we_q ? '0 : mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    done  = 1'b1;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done) begin
                    state_d = S_RESP;
                    if (owner_d_q) begin
                        dc_resp_d  = 1'b1;
                        dc_rdata_d = done_data;
                    end else begin
                        ic_resp_d  = 1'b1;
                        ic_rdata_d = done_data;
                    end
                end
            end
            S_RESP: begin
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_d_q    <= 1'b1;
            owner_d_q   <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_resp_q   <= 1'b0;
            dc_resp_q   <= 1'b0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            owner_d_q   <= owner_d_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_resp_q   <= ic_resp_d;
            dc_resp_q   <= dc_resp_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign ic_resp_valid = ic_resp_q;
    assign ic_rdata      = ic_rdata_q;
    assign dc_resp_valid = dc_resp_q;
    assign dc_rdata      = dc_rdata_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign busy          = busy_q;
    assign err           = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model, latency-programmable memory,
// directed requester scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_resp_valid;
    logic [LW-1:0] ic_rdata;
    logic          dc_req = 1'b0;
    logic          dc_we = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [LW-1:0] dc_wdata = '0;
    logic          dc_resp_valid;
    logic [LW-1:0] dc_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_resp_valid = 1'b0;
    logic [LW-1:0] mem_rdata = '0;
    logic          busy;
    logic          err;

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_resp_valid(ic_resp_valid), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_resp_valid(dc_resp_valid), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
        return {32'h0BADF00D, a, ~a, 32'hDEADBEEF};
    endfunction

    // Edge counter: after edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: answers a command seen in cycle G during cycle G+mem_lat (0 = never).
    int            mem_lat = 3;
    int            resp_at = -1;
    int            spur_at = -1;
    logic [AW-1:0] cap_addr = '0;
    always @(negedge clk) begin
        mem_resp_valid = (cyc == resp_at) || (cyc == spur_at);
        if (cyc == resp_at)      mem_rdata = line_for(cap_addr);
        else if (cyc == spur_at) mem_rdata = {4{32'hA5A55A5A}};
        else                     mem_rdata = '0;
        if (mem_req && mem_lat > 0) begin
            resp_at  = cyc + mem_lat;
            cap_addr = mem_addr;
        end
    end

    // Transaction-timeline model: a grant at edge g, completion at edge e (memory answer
    // seen at an edge in [g+2, g+TMO], else watchdog at g+TMO), port free again at e+2.
    bit            m_act = 0, m_done = 0, m_own_d = 0, m_we = 0, m_tmo = 0, m_last_d = 1;
    int            m_g = 0, m_e = 0, m_free = 0, m_c = 0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0, m_data = '0, m_ic_hold = '0, m_dc_hold = '0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 0; m_done = 0; m_tmo = 0; m_last_d = 1; m_free = 0;
            m_ic_hold = '0; m_dc_hold = '0;
        end else begin
            m_c = cyc + 1;
            if (m_act && !m_done) begin
                if (m_c >= m_g + 2) begin
                    if (mem_resp_valid) begin
                        m_done = 1; m_e = m_c; m_tmo = 0;
                        m_data = m_we ? '0 : line_for(m_addr);
                    end else if (m_c == m_g + TMO) begin
                        m_done = 1; m_e = m_c; m_tmo = 1; m_data = '0;
                    end
                    if (m_done) begin
                        if (m_own_d) m_dc_hold = m_data;
                        else         m_ic_hold = m_data;
                    end
                end
            end else if (m_act && m_done) begin
                if (m_c == m_e + 1) begin
                    m_act = 0; m_free = m_c + 1;
                end
            end else if (m_c >= m_free && (ic_req || dc_req)) begin
                if (ic_req && dc_req) m_own_d = !m_last_d;
                else                  m_own_d = dc_req;
                m_last_d = m_own_d;
                m_act = 1; m_done = 0; m_g = m_c;
                m_we    = m_own_d && dc_we;
                m_addr  = m_own_d ? dc_addr : ic_addr;
                m_wdata = m_own_d ? dc_wdata : '0;
            end
        end
    end

    // Per-cycle compare against the model, plus event capture for literal checks.
    int            n_ic = 0, n_dc = 0, n_err = 0;
    int            mreq_cyc = -1, ic_cyc = -1, dc_cyc = -1, err_cyc = -1;
    logic          seen_we = 0;
    logic [AW-1:0] seen_addr = '0;
    logic [LW-1:0] seen_wdata = '0;
    int            order[$];
    always @(negedge clk) begin
        chkb("mem_req", mem_req, m_act && cyc == m_g);
        chkb("busy", busy, m_act);
        chkb("ic_resp_valid", ic_resp_valid, m_act && m_done && cyc == m_e && !m_own_d);
        chkb("dc_resp_valid", dc_resp_valid, m_act && m_done && cyc == m_e && m_own_d);
        chkb("err", err, m_act && m_done && cyc == m_e && m_tmo);
        if (m_act) begin
            chkb("mem_we", mem_we, m_we);
            chk("mem_addr", LW'(mem_addr), LW'(m_addr));
            if (m_own_d) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("ic_rdata", ic_rdata, m_ic_hold);
        chk("dc_rdata", dc_rdata, m_dc_hold);
        if (mem_req) begin
            mreq_cyc = cyc; seen_we = mem_we; seen_addr = mem_addr; seen_wdata = mem_wdata;
        end
        if (ic_resp_valid) begin n_ic++; ic_cyc = cyc; order.push_back(0); end
        if (dc_resp_valid) begin n_dc++; dc_cyc = cyc; order.push_back(1); end
        if (err) begin n_err++; err_cyc = cyc; end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_ic(input logic [AW-1:0] a);
        bit got;
        got = 0;
        step();
        ic_req = 1'b1; ic_addr = a;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (ic_resp_valid) got = 1;
        end
        #1;
        ic_req = 1'b0;
        chkb("ic_txn_completes", got, 1'b1);
    endtask

    task automatic do_dc(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        bit got;
        got = 0;
        step();
        dc_req = 1'b1; dc_we = we; dc_addr = a; dc_wdata = wd;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (dc_resp_valid) got = 1;
        end
        #1;
        dc_req = 1'b0;
        chkb("dc_txn_completes", got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int b_ic, b_dc, b_err, n, base;
        bit found;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_ic_resp", ic_resp_valid, 1'b0);
        chkb("rst_err", err, 1'b0);
        chk("rst_ic_rdata", ic_rdata, '0);
        reset = 1'b0;

        // Single I read, memory latency 3.
        mem_lat = 3;
        do_ic(32'h80);
        chki("i_read_latency", ic_cyc - mreq_cyc, 4);
        chk("i_read_data", ic_rdata, 128'h0BADF00D_00000080_FFFFFF7F_DEADBEEF);
        chki("i_read_no_dc_pulse", n_dc, 0);
        chkb("i_read_mem_we", seen_we, 1'b0);

        // D refill then D write-back.
        mem_lat = 2;
        do_dc(1'b0, 32'h100, '0);
        chk("d_read_data", dc_rdata, 128'h0BADF00D_00000100_FFFFFEFF_DEADBEEF);
        mem_lat = 5;
        do_dc(1'b1, 32'h40, 128'h1111_2222_3333_4444);
        chkb("d_wb_mem_we", seen_we, 1'b1);
        chk("d_wb_mem_addr", LW'(seen_addr), LW'(32'h40));
        chk("d_wb_mem_wdata", seen_wdata, 128'h1111_2222_3333_4444);
        chk("d_wb_rdata_zero", dc_rdata, '0);
        chki("d_wb_latency", dc_cyc - mreq_cyc, 6);

        // Both requesting at reset release: I, D, I.
        step();
        reset = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h200;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h300;
        mem_lat = 2;
        step();
        order.delete();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 300 && n < 3; i++) begin
            @(negedge clk);
            if (ic_resp_valid || dc_resp_valid) n++;
        end
        #1;
        ic_req = 1'b0; dc_req = 1'b0;
        chki("rr_count", order.size(), 3);
        if (order.size() >= 3) begin
            chki("rr_first_i", order[0], 0);
            chki("rr_second_d", order[1], 1);
            chki("rr_third_i", order[2], 0);
        end

        // Watchdog with a D read that memory never answers.
        repeat (3) step();
        mem_lat = 0;
        b_err = n_err;
        do_dc(1'b0, 32'h500, '0);
        chki("tmo_err_count", n_err - b_err, 1);
        chki("tmo_latency", err_cyc - mreq_cyc, 64);
        chki("tmo_err_with_resp", err_cyc, dc_cyc);
        chk("tmo_rdata_zero", dc_rdata, '0);
        @(negedge clk);
        chkb("tmo_busy_falls", busy, 1'b0);

        // Reset in the middle of WAIT aborts silently.
        mem_lat = 10;
        b_ic = n_ic; b_dc = n_dc; b_err = n_err;
        step();
        ic_req = 1'b1; ic_addr = 32'h600;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_req) found = 1;
        end
        chkb("abort_issue_seen", found, 1'b1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        ic_req = 1'b0;
        #1;
        chkb("abort_busy", busy, 1'b0);
        chkb("abort_mem_req", mem_req, 1'b0);
        chk("abort_mem_addr", LW'(mem_addr), '0);
        chk("abort_ic_rdata", ic_rdata, '0);
        step();
        step();
        reset = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        chki("abort_no_ic_pulse", n_ic - b_ic, 0);
        chki("abort_no_dc_pulse", n_dc - b_dc, 0);
        chki("abort_no_err", n_err - b_err, 0);

        // Spurious memory response while idle.
        base = n_ic + n_dc;
        spur_at = cyc + 2;
        repeat (6) @(negedge clk);
        #1;
        chki("spurious_no_pulse", n_ic + n_dc - base, 0);
        chkb("spurious_idle", busy, 1'b0);

        // Port still usable afterwards.
        mem_lat = 1;
        do_ic(32'h700);
        chk("post_i_read_data", ic_rdata, line_for(32'h700));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
